// File: rtl/route_arb_pkg.sv
// Shared constants and helpers for the route arbiter.
// No logic; referenced by the interface, the per-direction slice and the top.
// Direction code 0 means "no direction" and never reaches arbitration.
package route_arb_pkg;

  localparam int DIR_NONE   = 0;
  localparam int NUM_IN_DEF = 3;
  localparam int DIR_W_DEF  = 2;
  localparam int AGE_W_DEF  = 3;

  // Number of real output directions for a given direction-code width.
  function automatic int num_dir(input int dir_w);
    return (1 << dir_w) - 1;
  endfunction

endpackage

// File: rtl/route_arbiter_if.sv
// Request/grant bundle between requesting inputs and the route arbiter.
// Pure wiring, no latency.
// out_ready carries per-direction backpressure into the arbiter.
interface route_arbiter_if
  import route_arb_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DIR_W  = DIR_W_DEF
);
  localparam int NUM_DIR = num_dir(DIR_W);

  logic                    enable;
  logic [NUM_IN-1:0]       req_valid;
  logic [NUM_IN*DIR_W-1:0] req_dir;
  logic [NUM_IN-1:0]       req_last;
  logic [NUM_DIR-1:0]      out_ready;
  logic [NUM_IN-1:0]       grant;
  logic [NUM_IN-1:0]       fail;
  logic [NUM_DIR-1:0]      lock_busy;

  modport master (
    output enable, req_valid, req_dir, req_last, out_ready,
    input  grant, fail, lock_busy
  );

  modport slave (
    input  enable, req_valid, req_dir, req_last, out_ready,
    output grant, fail, lock_busy
  );

endinterface

// File: rtl/route_arb_dir.sv
// One output direction: candidate select (lock, then age, then round-robin), packet lock, rr pointer.
// Grant/fail are combinational from the requests; lock and pointer update on the next edge.
// out_ready low stalls the direction: no grant, no fail, no state change.
module route_arb_dir
  import route_arb_pkg::*;
#(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int DIR_W    = DIR_W_DEF,
  parameter int AGE_W    = AGE_W_DEF,
  parameter int DIR_CODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_IN-1:0]       req_valid,
  input  logic [NUM_IN*DIR_W-1:0] req_dir,
  input  logic [NUM_IN-1:0]       req_last,
  input  logic [NUM_IN*AGE_W-1:0] age,
  input  logic                    out_ready,
  output logic [NUM_IN-1:0]       grant,
  output logic [NUM_IN-1:0]       fail,
  output logic                    lock_busy
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam logic [DIR_W-1:0] CODE = DIR_W'(DIR_CODE);

  logic              lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]  lock_own_q, lock_own_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0] cand;
  logic [NUM_IN-1:0] win_oh;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [AGE_W-1:0]  best_age;
  logic [IDX_W:0]    sum;
  logic [IDX_W-1:0]  idx;
  logic              active;

  // Inputs whose current flit targets this direction.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand[i] = req_valid[i] && (req_dir[i*DIR_W +: DIR_W] == CODE) && (DIR_CODE != DIR_NONE);
    end
  end

  // Winner: the lock owner if locked, else oldest candidate, ties to first at/after rr_ptr.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    best_age = '0;
    sum      = '0;
    idx      = '0;
    if (lock_vld_q) begin
      win_idx = lock_own_q;
      win_vld = cand[lock_own_q];
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_IN)) begin
          sum = sum - (IDX_W+1)'(NUM_IN);
        end
        idx = sum[IDX_W-1:0];
        // Strictly-greater keeps the earliest index in cyclic order on a tie.
        if (cand[idx] && (!win_vld || (age[idx*AGE_W +: AGE_W] > best_age))) begin
          win_vld  = 1'b1;
          win_idx  = idx;
          best_age = age[idx*AGE_W +: AGE_W];
        end
      end
    end
  end

  // Grant the winner, fail everyone else aiming here; nothing happens while stalled.
  always_comb begin
    active = enable && !rst && out_ready;
    win_oh = '0;
    win_oh[win_idx] = 1'b1;
    grant  = '0;
    fail   = '0;
    if (active) begin
      grant = win_vld ? win_oh : '0;
      // A locked direction whose owner is absent still fails all other candidates.
      fail  = cand & ~win_oh;
    end
  end

  // Lock follows the granted flit's tail bit; pointer moves past each granted input.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    rr_ptr_d   = rr_ptr_q;
    if (|grant) begin
      lock_vld_d = !req_last[win_idx];
      lock_own_d = win_idx;
      rr_ptr_d   = (win_idx == IDX_W'(NUM_IN - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Direction state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign lock_busy = lock_vld_q;

endmodule

// File: rtl/route_arbiter.sv
// Multi-input to multi-direction flit arbiter with packet locking and age-based fairness.
// Grant/fail combinational in the request cycle; ages, locks and pointers update next edge.
// Per-direction out_ready stalls only that direction; inputs hold their flit until granted.
module route_arbiter
  import route_arb_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DIR_W  = DIR_W_DEF,
  parameter int AGE_W  = AGE_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  route_arbiter_if.slave  bus
);

  localparam int NUM_DIR = num_dir(DIR_W);

  logic [NUM_DIR-1:0][NUM_IN-1:0] dir_grant;
  logic [NUM_DIR-1:0][NUM_IN-1:0] dir_fail;
  logic [NUM_DIR-1:0]             lock_vec;
  logic [NUM_IN-1:0]              grant_all;
  logic [NUM_IN-1:0]              fail_all;
  logic [NUM_IN-1:0][AGE_W-1:0]   age_q, age_d;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    route_arb_dir #(
      .NUM_IN   (NUM_IN),
      .DIR_W    (DIR_W),
      .AGE_W    (AGE_W),
      .DIR_CODE (d + 1)
    ) u_dir (
      .clk       (clk),
      .rst       (rst),
      .enable    (bus.enable),
      .req_valid (bus.req_valid),
      .req_dir   (bus.req_dir),
      .req_last  (bus.req_last),
      .age       (age_q),
      .out_ready (bus.out_ready[d]),
      .grant     (dir_grant[d]),
      .fail      (dir_fail[d]),
      .lock_busy (lock_vec[d])
    );
  end

  // Each input targets one direction, so OR-merging the slices cannot collide.
  always_comb begin
    grant_all = '0;
    fail_all  = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      grant_all = grant_all | dir_grant[d];
      fail_all  = fail_all  | dir_fail[d];
    end
  end

  // Age climbs (saturating) on each loss and resets on a win.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_all[i]) begin
        age_d[i] = '0;
      end else if (fail_all[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  // Age register.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign bus.grant     = grant_all;
  assign bus.fail      = fail_all;
  assign bus.lock_busy = lock_vec;

endmodule

// File: tb/tb_route_arbiter.sv
// Directed-vector bench for route_arbiter with hand-computed grant/fail/lock_busy values.
// Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
// Each vector occupies one clock cycle.
module tb_route_arbiter;

  localparam int NUM_IN = 3;
  localparam int DIR_W  = 2;
  localparam int AGE_W  = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  route_arbiter_if #(.NUM_IN(NUM_IN), .DIR_W(DIR_W)) bus ();

  route_arbiter #(.NUM_IN(NUM_IN), .DIR_W(DIR_W), .AGE_W(AGE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Directions listed as input2, input1, input0.
  task automatic drive(input logic en, input logic [2:0] vld, input logic [1:0] d2,
                       input logic [1:0] d1, input logic [1:0] d0,
                       input logic [2:0] lst, input logic [2:0] rdy);
    bus.enable    = en;
    bus.req_valid = vld;
    bus.req_dir   = {d2, d1, d0};
    bus.req_last  = lst;
    bus.out_ready = rdy;
  endtask

  // Check this cycle's grant/fail, then advance to just after the next edge.
  task automatic step(input string tag, input logic [2:0] eg, input logic [2:0] ef);
    #2;
    chk({tag, ".grant"}, 8'(bus.grant), 8'(eg));
    chk({tag, ".fail"},  8'(bus.fail),  8'(ef));
    @(posedge clk);
    #1;
  endtask

  task automatic lb(input string tag, input logic [2:0] exp);
    chk({tag, ".lock_busy"}, 8'(bus.lock_busy), 8'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b1, 3'b011, 2'd0, 2'd1, 2'd1, 3'b111, 3'b111);
    #1;
    step("rst_hold", 3'b000, 3'b000);
    lb("rst_clear", 3'b000);
    rst = 1'b0;

    // Equal ages, pointer 0: input 0 first, then the aged input 1.
    step("arb_first", 3'b001, 3'b010);
    step("arb_age",   3'b010, 3'b001);

    // Input 1 holds dir 3 for three flits so input 2 ages to 3.
    drive(1'b1, 3'b110, 2'd3, 2'd3, 2'd0, 3'b000, 3'b111);
    step("lk_f1", 3'b010, 3'b100);
    lb("lk_busy1", 3'b100);
    step("lk_f2", 3'b010, 3'b100);
    lb("lk_busy2", 3'b100);
    drive(1'b1, 3'b110, 2'd3, 2'd3, 2'd0, 3'b010, 3'b111);
    step("lk_f3", 3'b010, 3'b100);
    lb("lk_clr", 3'b000);

    // Age 3 beats age 1 with rr_ptr at 0; afterwards age[2] is back to 0.
    drive(1'b1, 3'b101, 2'd2, 2'd0, 2'd2, 3'b111, 3'b111);
    step("age_win", 3'b100, 3'b001);
    step("age_clr", 3'b001, 3'b100);

    // Three-flit packet from input 0 to dir 3 against input 1.
    drive(1'b1, 3'b011, 2'd0, 2'd3, 2'd3, 3'b010, 3'b111);
    lb("pk_pre", 3'b000);
    step("pk_f1", 3'b001, 3'b010);
    lb("pk_c2", 3'b100);
    step("pk_f2", 3'b001, 3'b010);
    lb("pk_c3", 3'b100);
    drive(1'b1, 3'b011, 2'd0, 2'd3, 2'd3, 3'b011, 3'b111);
    step("pk_f3", 3'b001, 3'b010);
    lb("pk_c4", 3'b000);
    drive(1'b1, 3'b010, 2'd0, 2'd3, 2'd0, 3'b010, 3'b111);
    step("pk_in1", 3'b010, 3'b000);

    // Dir 1 not ready: full stall, ages untouched, then input 0 wins from ptr 2.
    drive(1'b1, 3'b011, 2'd0, 2'd1, 2'd1, 3'b111, 3'b110);
    step("stall1", 3'b000, 3'b000);
    step("stall2", 3'b000, 3'b000);
    drive(1'b1, 3'b011, 2'd0, 2'd1, 2'd1, 3'b111, 3'b111);
    step("unstall", 3'b001, 3'b010);

    // Disabled: nothing moves; aged input 1 wins once re-enabled.
    drive(1'b0, 3'b011, 2'd0, 2'd1, 2'd1, 3'b111, 3'b111);
    step("dis1", 3'b000, 3'b000);
    step("dis2", 3'b000, 3'b000);
    drive(1'b1, 3'b011, 2'd0, 2'd1, 2'd1, 3'b111, 3'b111);
    step("reen", 3'b010, 3'b001);

    // Disjoint directions all granted; direction 0 requests are ignored.
    drive(1'b1, 3'b111, 2'd3, 2'd2, 2'd1, 3'b111, 3'b111);
    step("parallel", 3'b111, 3'b000);
    drive(1'b1, 3'b111, 2'd0, 2'd1, 2'd0, 3'b111, 3'b111);
    step("dir0", 3'b010, 3'b000);

    // Reset mid-packet on dir 2 frees the direction for a new requester.
    drive(1'b1, 3'b001, 2'd0, 2'd0, 2'd2, 3'b000, 3'b111);
    step("mid_f1", 3'b001, 3'b000);
    lb("mid_lock", 3'b010);
    rst = 1'b1;
    drive(1'b1, 3'b010, 2'd0, 2'd2, 2'd0, 3'b010, 3'b111);
    step("mid_rst", 3'b000, 3'b000);
    rst = 1'b0;
    lb("mid_clr", 3'b000);
    step("mid_new", 3'b010, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
